// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_pkg : shared pipeline types and constants (fetch / decode)     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mips_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [0:0] {
    FETCH_RUN   = 1'b0,
    FETCH_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcPlus4;
    logic        valid;
  } if_id_t;

  // Empty IF/ID slot handed to ID when nothing real advances.
  function automatic if_id_t if_id_bubble(input logic [31:0] nop);
    if_id_t b;
    b.inst    = nop;
    b.pcPlus4 = 32'h0000_0000;
    b.valid   = 1'b0;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_if : imem, hazard/redirect and IF/ID signals of IF      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface fetch_stage_if;

  logic [31:0] instAddr;
  logic [31:0] instData;
  logic        stall;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic [31:0] ifIdInst;
  logic [31:0] ifIdPcPlus4;
  logic        ifIdValid;
  logic        misalignFlag;
  logic        fetchFault;
  logic [31:0] fetchCount;
  logic [31:0] bubbleCount;

  // master = the fetch stage itself; slave = memory, hazard unit and ID.
  modport master (
    output instAddr,
    input  instData,
    input  stall,
    input  redirectValid,
    input  redirectTarget,
    output ifIdInst,
    output ifIdPcPlus4,
    output ifIdValid,
    output misalignFlag,
    output fetchFault,
    output fetchCount,
    output bubbleCount
  );

  modport slave (
    input  instAddr,
    output instData,
    output stall,
    output redirectValid,
    output redirectTarget,
    input  ifIdInst,
    input  ifIdPcPlus4,
    input  ifIdValid,
    input  misalignFlag,
    input  fetchFault,
    input  fetchCount,
    input  bubbleCount
  );

endinterface
`default_nettype wire

// File: rtl/fetch_perf_counters.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_perf_counters : wrapping fetch / bubble event counters        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_perf_counters (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        fetch_inc_i,
  input  wire logic        bubble_inc_i,
  output logic [31:0]      fetch_count_o,
  output logic [31:0]      bubble_count_o
);

  logic [31:0] fetch_q, fetch_d;
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    fetch_d  = fetch_q;
    bubble_d = bubble_q;
    if (fetch_inc_i) begin
      fetch_d = fetch_q + 32'd1;
    end
    if (bubble_inc_i) begin
      bubble_d = bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_q  <= 32'h0000_0000;
      bubble_q <= 32'h0000_0000;
    end else begin
      fetch_q  <= fetch_d;
      bubble_q <= bubble_d;
    end
  end

  assign fetch_count_o  = fetch_q;
  assign bubble_count_o = bubble_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : PC, IF/ID register, redirect/stall and fetch faults   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = mips_pkg::RESET_PC,
  parameter int          IMEM_WORDS = 65536,
  parameter logic [31:0] NOP_INST   = mips_pkg::NOP_INST
) (
  input  wire logic         clk,
  input  wire logic         reset,
  fetch_stage_if.master     bus
);

  import mips_pkg::*;

  localparam logic [32:0] C_IMEM_WORDS = 33'(IMEM_WORDS);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_t       ifid_q, ifid_d;
  logic         misalign_q, misalign_d;
  logic         in_range;
  logic         fetch_inc;
  logic         bubble_inc;

  assign in_range = ({3'b000, pc_q[31:2]} < C_IMEM_WORDS);

  // Priority: stall, then redirect, then fault, then a normal fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ifid_d     = ifid_q;
    misalign_d = misalign_q;
    fetch_inc  = 1'b0;
    bubble_inc = 1'b0;

    if (bus.stall) begin
      bubble_inc = 1'b1;
    end else if (bus.redirectValid) begin
      pc_d       = {bus.redirectTarget[31:2], 2'b00};
      ifid_d     = if_id_bubble(NOP_INST);
      state_d    = FETCH_RUN;
      bubble_inc = 1'b1;
      if (bus.redirectTarget[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end else if (state_q == FETCH_FAULT) begin
      ifid_d     = if_id_bubble(NOP_INST);
      bubble_inc = 1'b1;
    end else if (in_range) begin
      ifid_d.inst    = bus.instData;
      ifid_d.pcPlus4 = pc_q + 32'd4;
      ifid_d.valid   = 1'b1;
      pc_d           = pc_q + 32'd4;
      fetch_inc      = 1'b1;
    end else begin
      state_d    = FETCH_FAULT;
      ifid_d     = if_id_bubble(NOP_INST);
      bubble_inc = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_RUN;
      pc_q       <= RESET_PC;
      ifid_q     <= if_id_bubble(NOP_INST);
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ifid_q     <= ifid_d;
      misalign_q <= misalign_d;
    end
  end

  fetch_perf_counters u_perf (
    .clk            (clk),
    .reset          (reset),
    .fetch_inc_i    (fetch_inc),
    .bubble_inc_i   (bubble_inc),
    .fetch_count_o  (bus.fetchCount),
    .bubble_count_o (bus.bubbleCount)
  );

  assign bus.instAddr     = pc_q;
  assign bus.ifIdInst     = ifid_q.inst;
  assign bus.ifIdPcPlus4  = ifid_q.pcPlus4;
  assign bus.ifIdValid    = ifid_q.valid;
  assign bus.misalignFlag = misalign_q;
  assign bus.fetchFault   = (state_q == FETCH_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : directed + random checks of two fetch_stage copies |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_fetch_stage;

  // Observable view of one fetch stage; the model uses the same layout.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] p4;
    logic        valid;
    logic        mis;
    logic        fault;
    logic [31:0] fc;
    logic [31:0] bc;
  } view_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] tgt = 32'h0;
  logic [31:0] mem [0:255];

  int    total = 0;
  int    bad   = 0;
  view_t ma, mb;
  view_t obs_a, obs_b;

  always #5 clk = ~clk;

  fetch_stage_if bus_a ();
  fetch_stage_if bus_b ();

  assign bus_a.instData       = mem[bus_a.instAddr[9:2]];
  assign bus_a.stall          = stall;
  assign bus_a.redirectValid  = rv;
  assign bus_a.redirectTarget = tgt;
  assign bus_b.instData       = mem[bus_b.instAddr[9:2]];
  assign bus_b.stall          = stall;
  assign bus_b.redirectValid  = rv;
  assign bus_b.redirectTarget = tgt;

  assign obs_a = {bus_a.instAddr, bus_a.ifIdInst, bus_a.ifIdPcPlus4, bus_a.ifIdValid,
                  bus_a.misalignFlag, bus_a.fetchFault, bus_a.fetchCount, bus_a.bubbleCount};
  assign obs_b = {bus_b.instAddr, bus_b.ifIdInst, bus_b.ifIdPcPlus4, bus_b.ifIdValid,
                  bus_b.misalignFlag, bus_b.fetchFault, bus_b.fetchCount, bus_b.bubbleCount};

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(65536), .NOP_INST(32'h0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(16), .NOP_INST(32'h0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // What one edge does to the stage, straight from the behavioural rules.
  function automatic view_t model_next(input view_t m, input bit r, input bit st,
                                       input bit rdr, input logic [31:0] t, input int words);
    view_t n = m;
    if (r) begin
      n = '0;
    end else if (st) begin
      n.bc = m.bc + 1;
    end else if (rdr) begin
      n.pc    = t & 32'hFFFF_FFFC;
      n.inst  = 32'h0;
      n.p4    = 32'h0;
      n.valid = 1'b0;
      n.mis   = m.mis | (t % 4 != 0);
      n.fault = 1'b0;
      n.bc    = m.bc + 1;
    end else if (m.fault || (longint'(m.pc / 4) >= longint'(words))) begin
      n.fault = 1'b1;
      n.inst  = 32'h0;
      n.p4    = 32'h0;
      n.valid = 1'b0;
      n.bc    = m.bc + 1;
    end else begin
      n.inst  = mem[(m.pc / 4) % 256];
      n.p4    = m.pc + 4;
      n.valid = 1'b1;
      n.pc    = m.pc + 4;
      n.fc    = m.fc + 1;
    end
    return n;
  endfunction

  task automatic step(input bit r, input bit st, input bit rdr, input logic [31:0] t);
    reset = r;
    stall = st;
    rv    = rdr;
    tgt   = t;
    ma = model_next(ma, r, st, rdr, t, 65536);
    mb = model_next(mb, r, st, rdr, t, 16);
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    rv    = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h80);
    total++; if (obs_a !== view_t'(0)) begin bad++; $display("FAIL reset_a: got %h want %h", obs_a, view_t'(0)); end
    total++; if (obs_b !== view_t'(0)) begin bad++; $display("FAIL reset_b: got %h want %h", obs_b, view_t'(0)); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_inst [2];
    exp_inst[0] = 32'h2008_0001;
    exp_inst[1] = 32'h2009_0002;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      total++;
      if (bus_a.ifIdInst !== exp_inst[i] || bus_a.ifIdPcPlus4 !== 32'(4 * (i + 1)) || bus_a.ifIdValid !== 1'b1) begin
        bad++;
        $display("FAIL seq%0d: got inst=%h p4=%h v=%b want inst=%h p4=%h v=1",
                 i, bus_a.ifIdInst, bus_a.ifIdPcPlus4, bus_a.ifIdValid, exp_inst[i], 4 * (i + 1));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      total++;
      if (bus_a.instAddr !== 32'h8 || bus_a.ifIdInst !== 32'h2009_0002 || bus_a.ifIdPcPlus4 !== 32'h8) begin
        bad++;
        $display("FAIL stall_hold: got pc=%h inst=%h p4=%h want pc=8 inst=20090002 p4=8",
                 bus_a.instAddr, bus_a.ifIdInst, bus_a.ifIdPcPlus4);
      end
    end
    total++; if (bus_a.bubbleCount !== 32'd2) begin bad++; $display("FAIL stall_bubbles: got %0d want 2", bus_a.bubbleCount); end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (bus_a.ifIdInst !== 32'h0109_5020 || bus_a.ifIdPcPlus4 !== 32'hC || bus_a.fetchCount !== 32'd3) begin
      bad++;
      $display("FAIL stall_resume: got inst=%h p4=%h fc=%0d want inst=01095020 p4=c fc=3",
               bus_a.ifIdInst, bus_a.ifIdPcPlus4, bus_a.fetchCount);
    end
  endtask

  task automatic test_redirect();
    step(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (bus_a.instAddr !== 32'h10) begin bad++; $display("FAIL redir_pre_pc: got %h want 10", bus_a.instAddr); end
    step(1'b0, 1'b0, 1'b1, 32'h40);
    total++;
    if (bus_a.ifIdValid !== 1'b0 || bus_a.ifIdInst !== 32'h0 || bus_a.instAddr !== 32'h40) begin
      bad++;
      $display("FAIL redir_bubble: got v=%b inst=%h pc=%h want v=0 inst=0 pc=40",
               bus_a.ifIdValid, bus_a.ifIdInst, bus_a.instAddr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (bus_a.ifIdInst !== mem[16] || bus_a.ifIdPcPlus4 !== 32'h44 || bus_a.ifIdValid !== 1'b1) begin
      bad++;
      $display("FAIL redir_target: got inst=%h p4=%h want inst=%h p4=44",
               bus_a.ifIdInst, bus_a.ifIdPcPlus4, mem[16]);
    end
  endtask

  task automatic test_redirect_stall();
    step(1'b0, 1'b1, 1'b1, 32'h80);
    total++; if (bus_a.instAddr !== 32'h44) begin bad++; $display("FAIL rs_hold: got pc=%h want 44", bus_a.instAddr); end
    step(1'b0, 1'b0, 1'b1, 32'h80);
    total++; if (bus_a.instAddr !== 32'h80) begin bad++; $display("FAIL rs_take: got pc=%h want 80", bus_a.instAddr); end
  endtask

  task automatic test_misalign();
    step(1'b0, 1'b0, 1'b1, 32'h46);
    total++;
    if (bus_a.instAddr !== 32'h44 || bus_a.misalignFlag !== 1'b1) begin
      bad++;
      $display("FAIL misalign_set: got pc=%h flag=%b want pc=44 flag=1", bus_a.instAddr, bus_a.misalignFlag);
    end
    step(1'b0, 1'b0, 1'b1, 32'h20);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (bus_a.misalignFlag !== 1'b1) begin bad++; $display("FAIL misalign_sticky: got %b want 1", bus_a.misalignFlag); end
  endtask

  task automatic test_fault();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (bus_b.instAddr !== 32'h40 || bus_b.fetchFault !== 1'b0 || bus_b.fetchCount !== 32'd16) begin
      bad++;
      $display("FAIL fault_edge: got pc=%h fault=%b fc=%0d want pc=40 fault=0 fc=16",
               bus_b.instAddr, bus_b.fetchFault, bus_b.fetchCount);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (bus_b.fetchFault !== 1'b1 || bus_b.instAddr !== 32'h40 || bus_b.ifIdValid !== 1'b0 || bus_b.bubbleCount !== 32'd2) begin
      bad++;
      $display("FAIL fault_stick: got fault=%b pc=%h v=%b bc=%0d want fault=1 pc=40 v=0 bc=2",
               bus_b.fetchFault, bus_b.instAddr, bus_b.ifIdValid, bus_b.bubbleCount);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    total++;
    if (bus_b.fetchFault !== 1'b0 || bus_b.instAddr !== 32'h0) begin
      bad++;
      $display("FAIL fault_exit: got fault=%b pc=%h want fault=0 pc=0", bus_b.fetchFault, bus_b.instAddr);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    total++;
    if (bus_b.ifIdInst !== mem[0] || bus_b.ifIdValid !== 1'b1) begin
      bad++;
      $display("FAIL fault_resume: got inst=%h v=%b want inst=%h v=1", bus_b.ifIdInst, bus_b.ifIdValid, mem[0]);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (bus_b.fetchFault !== 1'b1) begin bad++; $display("FAIL fault_again: got %b want 1", bus_b.fetchFault); end
    step(1'b1, 1'b0, 1'b1, 32'h44);
    total++; if (obs_b !== view_t'(0)) begin bad++; $display("FAIL fault_reset: got %h want %h", obs_b, view_t'(0)); end
  endtask

  task automatic test_random();
    bit          r, st, rdr;
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 99) < 2);
      st  = ($urandom_range(0, 99) < 25);
      rdr = ($urandom_range(0, 99) < 15);
      t   = 32'($urandom_range(0, 127));
      step(r, st, rdr, t);
      total++; if (obs_a !== ma) begin bad++; $display("FAIL rand_a cyc%0d: got %h want %h", i, obs_a, ma); end
      total++; if (obs_b !== mb) begin bad++; $display("FAIL rand_b cyc%0d: got %h want %h", i, obs_b, mb); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0001;
    mem[1] = 32'h2009_0002;
    mem[2] = 32'h0109_5020;
    ma = '0;
    mb = '0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_misalign();
    test_fault();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the asynchronous-read instruction memory and the ID stage.
- Owns the PC register and drives the word-aligned byte address into instruction memory.
- Captures the returned instruction and PC+4 into the IF/ID pipeline register.
- Handles load-use stalls, control-flow redirects, out-of-range fetch faults and fetch performance counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 65536, instruction memory depth in 32-bit words; legal fetch addresses are 0 .. 4*IMEM_WORDS-4.
- NOP_INST, 32'h0000_0000, encoding inserted as a bubble.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- instAddr  output  32  byte address to instruction memory; equals the current PC, combinational.
- instData  input  32  instruction word returned combinationally by instruction memory for instAddr.
- stall  input  1  load-use hazard hold from hazard unit.
- redirectValid  input  1  taken branch/jump resolved in ID.
- redirectTarget  input  32  byte target address for the redirect.
- ifIdInst  output  32  registered instruction to ID.
- ifIdPcPlus4  output  32  registered PC+4 of that instruction.
- ifIdValid  output  1  1 = real instruction, 0 = bubble.
- misalignFlag  output  1  sticky; a redirect target had bits [1:0] != 0.
- fetchFault  output  1  high while in the FAULT state.
- fetchCount  output  32  valid instructions delivered to ID.
- bubbleCount  output  32  cycles in which ID received or held a non-advancing slot.

Behaviour:
- Reset, when reset = 1 at an edge:
  - pc = RESET_PC, ifIdInst = NOP_INST, ifIdPcPlus4 = 0, ifIdValid = 0.
  - misalignFlag = 0, state = RUN, both counters = 0.
  - Reset mid-operation discards everything, including a simultaneous redirect or stall.
- States: RUN and FAULT.
- Bounds check: inRange = (pc >> 2) < IMEM_WORDS, evaluated combinationally on the current pc.
- Per-edge priority, highest first: reset, stall, redirectValid, fault, normal.
- stall = 1:
  - pc, IF/ID and state hold.
  - bubbleCount += 1.
  - A redirect that is asserted in the same cycle is ignored. ID holds the branch, so redirectValid is re-presented on the first unstalled cycle.
- redirectValid = 1, stall = 0:
  - pc = {redirectTarget[31:2], 2'b00}.
  - IF/ID = bubble (NOP_INST, valid 0, pcPlus4 0), which squashes the wrong-path fetch. There is no delay slot.
  - misalignFlag is set if redirectTarget[1:0] != 0.
  - state = RUN. This is the only exit from FAULT other than reset.
  - bubbleCount += 1.
- RUN, no stall, no redirect, inRange:
  - IF/ID = {instData, pc+4, 1}.
  - pc = pc+4. Addition is modulo 2^32, so pc wraps from 32'hFFFF_FFFC to 0.
  - fetchCount += 1.
- RUN, no stall, no redirect, not inRange:
  - state = FAULT, pc holds, IF/ID = bubble, bubbleCount += 1.
- FAULT, no stall, no redirect:
  - pc holds, IF/ID = bubble, bubbleCount += 1.
- fetchFault = (state == FAULT). It is registered, so it rises one cycle after the out-of-range pc is presented.
- Latency: an instruction at pc appears on ifIdInst the edge after pc is presented.
- The redirect penalty is exactly 1 bubble.
- Counters wrap modulo 2^32 and never saturate.
- instAddr is never modified by stall; it always equals pc.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INST constant.
  - Default RESET_PC.
  - Fetch state enum {RUN, FAULT}.
  - A typedef for the IF/ID bundle {inst, pcPlus4, valid}, reused by the ID stage.
- Natural sub-module: fetch_perf_counters. It holds the two 32-bit counters with increment enables and synchronous reset.
- PC/IF-ID logic and the FSM stay in fetch_stage.

Test Plan:
- Reset, then 3 cycles with memory words 0x20080001, 0x20090002, 0x01095020 at addresses 0, 4, 8:
  - ifIdInst follows that sequence, with ifIdPcPlus4 = 4, 8, 12 and valid = 1.
  - fetchCount = 3.
- Stall for 2 cycles at pc = 8:
  - instAddr stays 8 and IF/ID holds the 0x20090002 / pcPlus4 8 entry.
  - bubbleCount += 2.
  - The next cycle delivers 0x01095020.
- redirectValid with target 0x40 while pc = 0x10:
  - The next edge gives ifIdValid = 0, ifIdInst = 0, instAddr = 0x40.
  - The following edge delivers mem[0x10 words] with pcPlus4 0x44.
- redirectValid and stall asserted together, then redirectValid alone:
  - No pc change in the first cycle.
  - pc = target after the second cycle.
- Redirect target 0x46:
  - pc = 0x44 and misalignFlag = 1.
  - The flag stays 1 after further redirects, until reset.
- With IMEM_WORDS = 16, run to pc = 0x40:
  - fetchFault rises and pc sticks at 0x40 with bubbles only.
  - A redirect to 0 clears fetchFault and fetching resumes.
  - A reset asserted during FAULT also returns pc to 0 with all outputs at their reset values.
